// File: rtl/alu_controller.sv
// Sequencer for the Mini SRC 32-bit ALU: registers operands, holds them for an opcode-dependent
// number of cycles (multicycle MUL/DIV), and returns HI/LO/zero. Optional macro: DIV0_TRAP_EN.
module alu_controller #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_lo,
    output logic [31:0] resp_hi,
    output logic        resp_zero,
    output logic        resp_illegal,
    output logic        resp_div0,
    output logic        busy
);
    localparam logic [3:0] OP_MUL        = 4'b0101;
    localparam logic [3:0] OP_DIV        = 4'b0110;
    localparam logic [3:0] OP_LAST_LEGAL = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [3:0]  lat_next;
    logic        req_ready_reg;
    logic        busy_reg;
    logic        resp_valid_reg;
    logic [31:0] alu_a_reg;
    logic [31:0] alu_b_reg;
    logic [3:0]  alu_op_reg;
    logic [31:0] resp_lo_reg;
    logic [31:0] resp_hi_reg;
    logic        resp_zero_reg;
    logic        resp_illegal_reg;

`ifdef DIV0_TRAP_EN
    logic        div0_hit;
    logic        div0_pending_reg;
    logic        resp_div0_reg;

    assign div0_hit  = (req_op == OP_DIV) && (req_b == 32'd0);
    assign resp_div0 = resp_div0_reg;
`else
    assign resp_div0 = 1'b0;
`endif

    // Hold time for the ALU inputs; a trapped divide skips the divider entirely.
    always_comb begin
        lat_next = 4'd1;
        if (req_op == OP_MUL) begin
            lat_next = 4'(MUL_CYCLES);
        end else if (req_op == OP_DIV) begin
            lat_next = 4'(DIV_CYCLES);
        end
`ifdef DIV0_TRAP_EN
        if (div0_hit) begin
            lat_next = 4'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            req_ready_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            resp_valid_reg   <= 1'b0;
            alu_a_reg        <= 32'd0;
            alu_b_reg        <= 32'd0;
            alu_op_reg       <= 4'd0;
            resp_lo_reg      <= 32'd0;
            resp_hi_reg      <= 32'd0;
            resp_zero_reg    <= 1'b0;
            resp_illegal_reg <= 1'b0;
`ifdef DIV0_TRAP_EN
            div0_pending_reg <= 1'b0;
            resp_div0_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        alu_a_reg     <= req_a;
                        alu_b_reg     <= req_b;
                        alu_op_reg    <= req_op;
                        cnt_reg       <= lat_next;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= EXEC;
`ifdef DIV0_TRAP_EN
                        div0_pending_reg <= div0_hit;
`endif
                    end else begin
                        // ready rises on the first clock after reset release
                        req_ready_reg <= 1'b1;
                    end
                end
                EXEC: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        resp_illegal_reg <= (alu_op_reg > OP_LAST_LEGAL);
                        resp_valid_reg   <= 1'b1;
                        state_reg        <= DONE;
`ifdef DIV0_TRAP_EN
                        if (div0_pending_reg) begin
                            resp_lo_reg   <= 32'd0;
                            resp_hi_reg   <= 32'd0;
                            resp_zero_reg <= 1'b1;
                            resp_div0_reg <= 1'b1;
                        end else begin
                            resp_lo_reg   <= alu_result[31:0];
                            resp_hi_reg   <= alu_result[63:32];
                            resp_zero_reg <= alu_zero;
                            resp_div0_reg <= 1'b0;
                        end
`else
                        resp_lo_reg   <= alu_result[31:0];
                        resp_hi_reg   <= alu_result[63:32];
                        resp_zero_reg <= alu_zero;
`endif
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_reg;
    assign busy         = busy_reg;
    assign resp_valid   = resp_valid_reg;
    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_op       = alu_op_reg;
    assign resp_lo      = resp_lo_reg;
    assign resp_hi      = resp_hi_reg;
    assign resp_zero    = resp_zero_reg;
    assign resp_illegal = resp_illegal_reg;

endmodule

// File: tb/tb_alu_controller.sv
// Scoreboard bench for alu_controller: a behavioural ALU feeds the DUT, the driver queues
// hand-computed responses, and a negedge monitor compares each response as it appears.
module tb_alu_controller;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_lo;
    logic [31:0] resp_hi;
    logic        resp_zero;
    logic        resp_illegal;
    logic        resp_div0;
    logic        busy;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        logic        ill;
        logic        dz;
        int          lat;
        int          accept;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    alu_controller #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_lo(resp_lo), .resp_hi(resp_hi), .resp_zero(resp_zero),
        .resp_illegal(resp_illegal), .resp_div0(resp_div0), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: signed MUL, DIV gives quotient in LO and remainder in HI.
    always_comb begin
        alu_result = 64'd0;
        case (alu_op)
            OP_AND: alu_result = {32'd0, alu_a & alu_b};
            OP_ADD: alu_result = {32'd0, alu_a + alu_b};
            OP_MUL: alu_result = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
            OP_DIV: alu_result = (alu_b != 32'd0) ? {alu_a % alu_b, alu_a / alu_b}
                                                  : {32'hDEADBEEF, 32'hFFFFFFFF};
            default: alu_result = 64'd0;
        endcase
        alu_zero = (alu_result == 64'd0);
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic exp_t mk(input logic [31:0] lo, input logic [31:0] hi, input logic zero,
                                input logic ill, input logic dz, input int lat);
        exp_t e;
        e.lo = lo; e.hi = hi; e.zero = zero; e.ill = ill; e.dz = dz; e.lat = lat; e.accept = 0;
        return e;
    endfunction

    // Present one request; the response (if any) is checked by the monitor.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input bit push);
        int w;
        exp_t ee;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_total++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        ee = e;
        ee.accept = cyc + 1;
        if (push) sbq.push_back(ee);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int w;
        w = 0;
        while (!resp_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!resp_valid) begin
            n_total++;
            $display("FAIL %s_timeout: got resp_valid=0 expected 1", name);
        end
    endtask

    // Monitor: compare on the first cycle of each response, then require bit-stability.
    logic        prev_valid = 1'b0;
    logic [31:0] snap_lo, snap_hi;
    logic        snap_zero, snap_ill, snap_dz;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (sbq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_resp: got lo=%0h hi=%0h expected none", resp_lo, resp_hi);
                end else begin
                    e = sbq.pop_front();
                    $display("resp cyc=%0d lo=%08h hi=%08h zero=%0b ill=%0b div0=%0b",
                             cyc, resp_lo, resp_hi, resp_zero, resp_illegal, resp_div0);
                    chk("resp_lo", 64'(resp_lo), 64'(e.lo));
                    chk("resp_hi", 64'(resp_hi), 64'(e.hi));
                    chk("resp_zero", 64'(resp_zero), 64'(e.zero));
                    chk("resp_illegal", 64'(resp_illegal), 64'(e.ill));
                    chk("resp_div0", 64'(resp_div0), 64'(e.dz));
                    chk("latency", 64'(cyc - e.accept), 64'(e.lat));
                    chk("req_ready_in_done", 64'(req_ready), 64'd0);
                end
                snap_lo = resp_lo; snap_hi = resp_hi; snap_zero = resp_zero;
                snap_ill = resp_illegal; snap_dz = resp_div0;
            end else if (resp_valid) begin
                chk("hold_stable", {resp_lo, resp_hi[28:0], resp_zero, resp_illegal, resp_div0},
                    {snap_lo, snap_hi[28:0], snap_zero, snap_ill, snap_dz});
            end
            prev_valid = resp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {req_ready, busy, resp_valid, alu_a, alu_op, resp_lo, resp_zero,
                              resp_illegal, resp_div0}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        // ADD 5+7, latency 1
        issue(OP_ADD, 32'd5, 32'd7, mk(32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
        wait_valid("add");
        @(negedge clk);
        chk("alu_a_held_idle", 64'(alu_a), 64'd5);

        // MUL -1 * 2 (signed), latency MUL_CYCLES
        issue(OP_MUL, 32'hFFFFFFFF, 32'd2, mk(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4), 1'b1);
        wait_valid("mul");
        @(negedge clk);

        // DIV 17/5 with busy tracked through EXEC and DONE
        issue(OP_DIV, 32'd17, 32'd5, mk(32'd3, 32'd2, 1'b0, 1'b0, 1'b0, 8), 1'b1);
        w = 0;
        while (!resp_valid && w < 20) begin
            chk("busy_exec", 64'(busy), 64'd1);
            @(negedge clk);
            w++;
        end
        chk("busy_done", 64'(busy), 64'd1);
        @(negedge clk);
        chk("busy_after_hs", 64'(busy), 64'd0);

        // AND with back-pressure; a request presented while DONE must be ignored
        resp_ready = 1'b0;
        issue(OP_AND, 32'h0000F0F0, 32'h00000FF0, mk(32'h000000F0, 32'd0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
        wait_valid("and");
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd99; req_b = 32'd1;
            @(negedge clk);
            chk("req_ready_stall", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        chk("ignored_req_alu_a", 64'(alu_a), 64'h0000F0F0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("valid_clear_after_hs", 64'(resp_valid), 64'd0);
        chk("ready_after_hs", 64'(req_ready), 64'd1);

        // Reset in the middle of a DIV: outputs clear at once, no response afterwards
        issue(OP_DIV, 32'd100, 32'd7, mk(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8), 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_clear", {req_ready, busy, resp_valid, alu_a, alu_b[3:0], alu_op,
                                  resp_lo[15:0], resp_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("idle_after_reset", {busy, resp_valid, req_ready}, 64'b001);

        // Illegal opcode completes in one cycle with zero result
        issue(4'b1110, 32'd3, 32'd4, mk(32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1), 1'b1);
        wait_valid("illegal");
        @(negedge clk);

        // Divide by zero
`ifdef DIV0_TRAP_EN
        issue(OP_DIV, 32'd9, 32'd0, mk(32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1), 1'b1);
`else
        issue(OP_DIV, 32'd9, 32'd0, mk(32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8), 1'b1);
`endif
        wait_valid("div0");
        @(negedge clk);

        // Back-to-back: ADD wrap to zero right after the previous handshake
        issue(OP_ADD, 32'd1, 32'hFFFFFFFF, mk(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1), 1'b1);
        issue(OP_MUL, 32'd6, 32'd7, mk(32'd42, 32'd0, 1'b0, 1'b0, 1'b0, 4), 1'b1);
        wait_valid("b2b");

        w = 0;
        while (sbq.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
